// File: rtl/register_file_march_bist.sv
// register_file_march_bist
//   March C- self-test controller for the L1 instruction-cache register files.
//   It drives the register-file test wrapper's single-port interface, checks
//   the returned read data against the expected background, and reports
//   pass/fail with the first failing address and march element.
//
//   Element sequence (B0 = all zeros, B1 = all ones):
//     M0 up: w0 | M1 up: r0,w1 | M2 up: r1,w0 | M3 down: r0,w1 | M4 down: r1,w0 | M5 up: r0
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bist_start_i      one-cycle run request, accepted in IDLE or DONE only
//   bist_done_o       run finished; held until the next accepted start
//   bist_fail_o       mismatch seen; valid while bist_done_o = 1
//   bist_fail_addr_o  address of the first mismatch
//   bist_fail_elem_o  march element index (0..5) of the first mismatch
//   BIST              wrapper test-mode enable, high only while running
//   CSN_T, WEN_T      active-low chip select / write enable
//   A_T, D_T          test address / test write data
//   Q_T               test read data, valid READ_LAT cycles after a read issue
module register_file_march_bist #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bist_start_i,
  output logic                  bist_done_o,
  output logic                  bist_fail_o,
  output logic [ADDR_WIDTH-1:0] bist_fail_addr_o,
  output logic [2:0]            bist_fail_elem_o,
  output logic                  BIST,
  output logic                  CSN_T,
  output logic                  WEN_T,
  output logic [ADDR_WIDTH-1:0] A_T,
  output logic [DATA_WIDTH-1:0] D_T,
  input  logic [DATA_WIDTH-1:0] Q_T
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]            LAT       = 2'(READ_LAT);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [2:0]            ELEM_LAST = 3'd5;

  // Read ops: every op of M5, and the first op of M1..M4.
  function automatic logic f_is_read(input logic [2:0] elem, input logic op);
    return (elem == 3'd5) || ((elem != 3'd0) && !op);
  endfunction

  // Background of an op: expected data for reads, write data for writes.
  function automatic logic f_ones(input logic [2:0] elem, input logic op);
    if (f_is_read(elem, op)) return (elem == 3'd2) || (elem == 3'd4);
    return (elem == 3'd1) || (elem == 3'd3);
  endfunction

  // Position of the op presented on the bus in the current cycle.
  state_t                r_state, w_state_nxt;
  logic [2:0]            r_elem, w_elem_nxt;
  logic                  r_op, w_op_nxt;        // op index within the element
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [1:0]            r_lat, w_lat_nxt;      // 0 = issue cycle of a read
  logic [DATA_WIDTH-1:0] r_exp, w_exp_nxt;      // expected read data, set at issue

  // Registered outputs.
  logic                  r_bist, w_bist_nxt;
  logic                  r_csn, w_csn_nxt;
  logic                  r_wen, w_wen_nxt;
  logic [ADDR_WIDTH-1:0] r_a, w_a_nxt;
  logic [DATA_WIDTH-1:0] r_d, w_d_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_fail, w_fail_nxt;
  logic [ADDR_WIDTH-1:0] r_fail_addr, w_fail_addr_nxt;
  logic [2:0]            r_fail_elem, w_fail_elem_nxt;

  logic w_cur_read, w_cur_last_cycle, w_cur_last_op, w_cur_desc;
  logic w_addr_end, w_miscompare, w_issue, w_nxt_read;

  assign w_cur_read       = f_is_read(r_elem, r_op);
  assign w_cur_last_cycle = !w_cur_read || (r_lat == LAT);
  assign w_cur_last_op    = (r_elem == 3'd0) || (r_elem == ELEM_LAST) || r_op;
  assign w_cur_desc       = (r_elem == 3'd3) || (r_elem == 3'd4);
  assign w_addr_end       = w_cur_desc ? (r_addr == '0) : (r_addr == ADDR_MAX);
  // Compare in the last cycle of a read op (the issue cycle when READ_LAT = 0).
  assign w_miscompare     = (r_state == S_RUN) && w_cur_read && w_cur_last_cycle &&
                            (Q_T != r_exp);

  // NOTE: every variable gets a default before the case so that no path
  // leaves one unassigned and infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_elem_nxt      = r_elem;
    w_op_nxt        = r_op;
    w_addr_nxt      = r_addr;
    w_lat_nxt       = r_lat;
    w_exp_nxt       = r_exp;
    w_done_nxt      = r_done;
    w_fail_nxt      = r_fail;
    w_fail_addr_nxt = r_fail_addr;
    w_fail_elem_nxt = r_fail_elem;
    w_bist_nxt      = 1'b0;
    w_csn_nxt       = 1'b1;
    w_wen_nxt       = 1'b1;
    w_a_nxt         = '0;
    w_d_nxt         = '0;
    w_issue         = 1'b0;
    w_nxt_read      = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bist_start_i) begin
          w_state_nxt     = S_RUN;
          w_elem_nxt      = 3'd0;
          w_op_nxt        = 1'b0;
          w_addr_nxt      = '0;
          w_done_nxt      = 1'b0;
          w_fail_nxt      = 1'b0;
          w_fail_addr_nxt = '0;
          w_fail_elem_nxt = 3'd0;
          w_issue         = 1'b1;
        end
      end
      S_RUN: begin
        if (w_miscompare) begin
          w_state_nxt     = S_DONE;
          w_done_nxt      = 1'b1;
          w_fail_nxt      = 1'b1;
          w_fail_addr_nxt = r_addr;
          w_fail_elem_nxt = r_elem;
        end else if (!w_cur_last_cycle) begin
          // Read wait cycle: bus idle, address held.
          w_lat_nxt  = r_lat + 2'd1;
          w_bist_nxt = 1'b1;
          w_a_nxt    = r_addr;
        end else if (!w_cur_last_op) begin
          w_op_nxt = 1'b1;
          w_issue  = 1'b1;
        end else if (!w_addr_end) begin
          w_op_nxt   = 1'b0;
          w_addr_nxt = w_cur_desc ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
          w_issue    = 1'b1;
        end else if (r_elem == ELEM_LAST) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          // Straight into the next element; M3 and M4 start at the top.
          w_elem_nxt = r_elem + 3'd1;
          w_op_nxt   = 1'b0;
          w_addr_nxt = ((r_elem == 3'd2) || (r_elem == 3'd3)) ? ADDR_MAX : '0;
          w_issue    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Present the op selected above on the bus.
    if (w_issue) begin
      w_nxt_read = f_is_read(w_elem_nxt, w_op_nxt);
      w_lat_nxt  = 2'd0;
      w_bist_nxt = 1'b1;
      w_csn_nxt  = 1'b0;
      w_wen_nxt  = w_nxt_read;
      w_a_nxt    = w_addr_nxt;
      w_exp_nxt  = {DATA_WIDTH{f_ones(w_elem_nxt, w_op_nxt)}};
      w_d_nxt    = w_nxt_read ? '0 : w_exp_nxt;
    end
  end

  // NOTE: state and outputs are updated with non-blocking assignments so all
  // registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_elem      <= 3'd0;
      r_op        <= 1'b0;
      r_addr      <= '0;
      r_lat       <= 2'd0;
      r_exp       <= '0;
      r_bist      <= 1'b0;
      r_csn       <= 1'b1;
      r_wen       <= 1'b1;
      r_a         <= '0;
      r_d         <= '0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_elem      <= w_elem_nxt;
      r_op        <= w_op_nxt;
      r_addr      <= w_addr_nxt;
      r_lat       <= w_lat_nxt;
      r_exp       <= w_exp_nxt;
      r_bist      <= w_bist_nxt;
      r_csn       <= w_csn_nxt;
      r_wen       <= w_wen_nxt;
      r_a         <= w_a_nxt;
      r_d         <= w_d_nxt;
      r_done      <= w_done_nxt;
      r_fail      <= w_fail_nxt;
      r_fail_addr <= w_fail_addr_nxt;
      r_fail_elem <= w_fail_elem_nxt;
    end
  end

  assign BIST             = r_bist;
  assign CSN_T            = r_csn;
  assign WEN_T            = r_wen;
  assign A_T              = r_a;
  assign D_T              = r_d;
  assign bist_done_o      = r_done;
  assign bist_fail_o      = r_fail;
  assign bist_fail_addr_o = r_fail_addr;
  assign bist_fail_elem_o = r_fail_elem;

endmodule

// File: tb/tb_register_file_march_bist.sv
// Testbench for register_file_march_bist.
//   Instance 0: N=32, READ_LAT=1, memory model with selectable faults.
//   Instance 1: N=32, READ_LAT=0.   Instance 2: N=32, READ_LAT=3.
//   Instance 3: N=2,  READ_LAT=1.
module tb_register_file_march_bist;

  localparam int MAX_CYC = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] start = '0;

  logic [3:0]  bist_v, csn_v, wen_v, done_v, fail_v;
  logic [31:0] a_v  [4];
  logic [31:0] d_v  [4];
  logic [31:0] fa_v [4];
  logic [31:0] fe_v [4];

  // 0 = clean, 1 = addr 5 bit 3 stuck at 1, 2 = write 1 to addr 9 sets addr 8
  int fault_mode = 0;

  int vectors     = 0;
  int miscompares = 0;

  // Per-cycle trace of the most recent run (index 1 = first RUN cycle).
  int          tr_len;
  logic        tr_csn  [MAX_CYC+1];
  logic        tr_wen  [MAX_CYC+1];
  logic        tr_done [MAX_CYC+1];
  logic        tr_fail [MAX_CYC+1];
  logic [31:0] tr_a    [MAX_CYC+1];
  logic [31:0] tr_d    [MAX_CYC+1];
  logic [31:0] tr_fa   [MAX_CYC+1];
  logic [31:0] tr_fe   [MAX_CYC+1];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int AW  = (g == 3) ? 1 : 5;
    localparam int LAT = (g == 1) ? 0 : ((g == 2) ? 3 : 1);

    logic          bist, csn, wen, done, fail;
    logic [AW-1:0] a_t, fail_addr;
    logic [2:0]    fail_elem;
    logic [31:0]   d_t, q_t, rd_val;
    logic [31:0]   mem  [32];
    logic [31:0]   pipe [4];

    register_file_march_bist #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(32),
      .READ_LAT  (LAT)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bist_start_i    (start[g]),
      .bist_done_o     (done),
      .bist_fail_o     (fail),
      .bist_fail_addr_o(fail_addr),
      .bist_fail_elem_o(fail_elem),
      .BIST            (bist),
      .CSN_T           (csn),
      .WEN_T           (wen),
      .A_T             (a_t),
      .D_T             (d_t),
      .Q_T             (q_t)
    );

    always_comb begin
      rd_val = mem[int'(a_t)];
      if (g == 0 && fault_mode == 1 && int'(a_t) == 5) rd_val[3] = 1'b1;
    end

    always @(posedge clk) begin
      if (!csn && !wen) begin
        mem[int'(a_t)] <= d_t;
        if (g == 0 && fault_mode == 2 && int'(a_t) == 9 && d_t != 32'd0) mem[8] <= '1;
      end
      pipe[0] <= (!csn && wen) ? rd_val : 32'd0;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    if (LAT == 0) begin : g_q0
      assign q_t = rd_val;
    end else begin : g_qn
      assign q_t = pipe[LAT-1];
    end

    assign bist_v[g] = bist;
    assign csn_v[g]  = csn;
    assign wen_v[g]  = wen;
    assign done_v[g] = done;
    assign fail_v[g] = fail;
    assign a_v[g]    = 32'(a_t);
    assign d_v[g]    = d_t;
    assign fa_v[g]   = 32'(fail_addr);
    assign fe_v[g]   = 32'(fail_elem);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then record every cycle while BIST is high.
  // mid_start > 0 pulses start again during that RUN cycle.
  task automatic run_bist(input int idx, input int mid_start);
    start[idx] = 1'b1;
    tick();
    start[idx] = 1'b0;
    tr_len = 0;
    while (bist_v[idx] === 1'b1 && tr_len < MAX_CYC) begin
      tr_len++;
      tr_csn[tr_len]  = csn_v[idx];
      tr_wen[tr_len]  = wen_v[idx];
      tr_done[tr_len] = done_v[idx];
      tr_fail[tr_len] = fail_v[idx];
      tr_a[tr_len]    = a_v[idx];
      tr_d[tr_len]    = d_v[idx];
      tr_fa[tr_len]   = fa_v[idx];
      tr_fe[tr_len]   = fe_v[idx];
      start[idx] = (tr_len == mid_start);
      tick();
    end
    start[idx] = 1'b0;
    vectors++;
    if (tr_len >= MAX_CYC) begin
      miscompares++;
      $display("FAIL run_timeout inst %0d: BIST still high after %0d cycles, expected it to fall", idx, tr_len);
    end
  endtask

  function automatic int count_ops(input logic want_wen);
    int n = 0;
    for (int i = 1; i <= tr_len; i++) if (tr_csn[i] == 1'b0 && tr_wen[i] == want_wen) n++;
    return n;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({bist_v[i], csn_v[i], wen_v[i], done_v[i], fail_v[i]} !== 5'b01100) begin
        miscompares++;
        $display("FAIL reset_ctrl inst %0d: {BIST,CSN,WEN,done,fail}=%b expected 01100", i,
                 {bist_v[i], csn_v[i], wen_v[i], done_v[i], fail_v[i]});
      end
    end
    vectors++;
    if (a_v[0] !== 0 || d_v[0] !== 0 || fa_v[0] !== 0 || fe_v[0] !== 0) begin
      miscompares++;
      $display("FAIL reset_data: A=%0d D=%h fa=%0d fe=%0d expected all 0", a_v[0], d_v[0], fa_v[0], fe_v[0]);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_run();
    fault_mode = 0;
    run_bist(0, 0);
    vectors++;
    if (tr_len !== 480) begin miscompares++; $display("FAIL clean_len: got %0d expected 480", tr_len); end
    vectors++;
    if ({tr_csn[1], tr_wen[1], tr_done[1]} !== 3'b000 || tr_a[1] !== 0 || tr_d[1] !== 0) begin
      miscompares++;
      $display("FAIL first_access: csn=%b wen=%b done=%b A=%0d D=%h expected w0 @0, done 0",
               tr_csn[1], tr_wen[1], tr_done[1], tr_a[1], tr_d[1]);
    end
    vectors++;
    if ({tr_csn[33], tr_wen[33]} !== 2'b01 || tr_a[33] !== 0 || tr_d[33] !== 0) begin
      miscompares++;
      $display("FAIL m1_read_issue: csn=%b wen=%b A=%0d D=%h expected read @0", tr_csn[33], tr_wen[33], tr_a[33], tr_d[33]);
    end
    vectors++;
    if ({tr_csn[34], tr_wen[34]} !== 2'b11 || tr_a[34] !== 0) begin
      miscompares++;
      $display("FAIL m1_read_wait: csn=%b wen=%b A=%0d expected idle, A held 0", tr_csn[34], tr_wen[34], tr_a[34]);
    end
    vectors++;
    if ({tr_csn[35], tr_wen[35]} !== 2'b00 || tr_a[35] !== 0 || tr_d[35] !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL m1_write1: csn=%b wen=%b A=%0d D=%h expected w1 @0", tr_csn[35], tr_wen[35], tr_a[35], tr_d[35]);
    end
    vectors++;
    if ({tr_csn[225], tr_wen[225]} !== 2'b01 || tr_a[225] !== 31) begin
      miscompares++;
      $display("FAIL m3_first: csn=%b wen=%b A=%0d expected read @31", tr_csn[225], tr_wen[225], tr_a[225]);
    end
    vectors++;
    if (count_ops(1'b0) !== 160 || count_ops(1'b1) !== 160) begin
      miscompares++;
      $display("FAIL op_counts: writes=%0d reads=%0d expected 160/160", count_ops(1'b0), count_ops(1'b1));
    end
    vectors++;
    if ({done_v[0], fail_v[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL clean_result: done=%b fail=%b expected 1/0", done_v[0], fail_v[0]);
    end
  endtask

  task automatic test_read_latency();
    run_bist(1, 0);
    vectors++;
    if (tr_len !== 320 || {done_v[1], fail_v[1]} !== 2'b10) begin
      miscompares++;
      $display("FAIL lat0_run: len=%0d done=%b fail=%b expected 320,1,0", tr_len, done_v[1], fail_v[1]);
    end
    vectors++;
    if ({tr_csn[34], tr_wen[34]} !== 2'b00 || tr_a[34] !== 0 || tr_d[34] !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL lat0_no_wait: csn=%b wen=%b A=%0d D=%h expected w1 @0", tr_csn[34], tr_wen[34], tr_a[34], tr_d[34]);
    end
    run_bist(2, 0);
    vectors++;
    if (tr_len !== 800 || {done_v[2], fail_v[2]} !== 2'b10) begin
      miscompares++;
      $display("FAIL lat3_run: len=%0d done=%b fail=%b expected 800,1,0", tr_len, done_v[2], fail_v[2]);
    end
  endtask

  task automatic test_small_n();
    run_bist(3, 0);
    vectors++;
    if (tr_len !== 30 || {done_v[3], fail_v[3]} !== 2'b10) begin
      miscompares++;
      $display("FAIL n2_run: len=%0d done=%b fail=%b expected 30,1,0", tr_len, done_v[3], fail_v[3]);
    end
    vectors++;
    if ({tr_csn[15], tr_wen[15]} !== 2'b01 || tr_a[15] !== 1 || {tr_csn[18], tr_wen[18]} !== 2'b01 || tr_a[18] !== 0) begin
      miscompares++;
      $display("FAIL n2_descend: A@15=%0d A@18=%0d expected reads at 1 then 0", tr_a[15], tr_a[18]);
    end
  endtask

  task automatic test_stuck_at();
    int extra;
    fault_mode = 1;
    run_bist(0, 0);
    vectors++;
    if (tr_len !== 49) begin miscompares++; $display("FAIL stuck_len: got %0d expected 49", tr_len); end
    vectors++;
    if ({done_v[0], fail_v[0]} !== 2'b11 || fa_v[0] !== 5 || fe_v[0] !== 1) begin
      miscompares++;
      $display("FAIL stuck_result: done=%b fail=%b addr=%0d elem=%0d expected 1,1,5,1", done_v[0], fail_v[0], fa_v[0], fe_v[0]);
    end
    vectors++;
    if (count_ops(1'b0) + count_ops(1'b1) !== 43 || tr_csn[49] !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck_accesses: got %0d, last csn=%b expected 43, 1", count_ops(1'b0) + count_ops(1'b1), tr_csn[49]);
    end
    extra = 0;
    repeat (4) begin
      if (csn_v[0] !== 1'b1 || bist_v[0] !== 1'b0 || done_v[0] !== 1'b1) extra++;
      tick();
    end
    vectors++;
    if (extra !== 0) begin miscompares++; $display("FAIL done_hold: %0d bad cycles after abort, expected 0", extra); end
  endtask

  task automatic test_restart_after_fail();
    fault_mode = 0;
    run_bist(0, 0);
    vectors++;
    if ({tr_done[1], tr_fail[1]} !== 2'b00 || tr_fa[1] !== 0 || tr_fe[1] !== 0) begin
      miscompares++;
      $display("FAIL restart_clear: done=%b fail=%b addr=%0d elem=%0d expected all 0", tr_done[1], tr_fail[1], tr_fa[1], tr_fe[1]);
    end
    vectors++;
    if (tr_len !== 480 || {done_v[0], fail_v[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL restart_run: len=%0d done=%b fail=%b expected 480,1,0", tr_len, done_v[0], fail_v[0]);
    end
  endtask

  task automatic test_coupling();
    fault_mode = 2;
    run_bist(0, 0);
    vectors++;
    if (tr_len !== 295 || {done_v[0], fail_v[0]} !== 2'b11 || fa_v[0] !== 8 || fe_v[0] !== 3) begin
      miscompares++;
      $display("FAIL coupling: len=%0d done=%b fail=%b addr=%0d elem=%0d expected 295,1,1,8,3",
               tr_len, done_v[0], fail_v[0], fa_v[0], fe_v[0]);
    end
    fault_mode = 0;
  endtask

  task automatic test_start_during_run();
    run_bist(0, 200);
    vectors++;
    if (tr_len !== 480 || {done_v[0], fail_v[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL start_in_run: len=%0d done=%b fail=%b expected 480,1,0", tr_len, done_v[0], fail_v[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (99) tick();
    // Cycle 100: read wait at M1 address 22.
    vectors++;
    if ({bist_v[0], csn_v[0]} !== 2'b11 || a_v[0] !== 22) begin
      miscompares++;
      $display("FAIL pre_reset: BIST=%b csn=%b A=%0d expected 1,1,22", bist_v[0], csn_v[0], a_v[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bist_v[0], csn_v[0], wen_v[0], done_v[0], fail_v[0]} !== 5'b01100 ||
        a_v[0] !== 0 || d_v[0] !== 0 || fa_v[0] !== 0 || fe_v[0] !== 0) begin
      miscompares++;
      $display("FAIL async_reset: BIST=%b csn=%b wen=%b done=%b fail=%b A=%0d expected reset values",
               bist_v[0], csn_v[0], wen_v[0], done_v[0], fail_v[0], a_v[0]);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_bist(0, 0);
    vectors++;
    if (tr_len !== 480 || {done_v[0], fail_v[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL post_reset_run: len=%0d done=%b fail=%b expected 480,1,0", tr_len, done_v[0], fail_v[0]);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_read_latency();
    test_small_n();
    test_stuck_at();
    test_restart_after_fail();
    test_coupling();
    test_start_during_run();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_file_march_bist.md
# register_file_march_bist

March C- built-in self-test controller for the latch/flip-flop register files in the L1 instruction cache. It sits directly upstream of the register-file test wrapper. It drives that wrapper's BIST-enable and single-port test interface (chip-select, write-enable, address, data) and checks the returned test read data. When the test completes, it reports pass/fail plus the first failing address and march element to the cache's test/configuration logic.

## Interface
- `ADDR_WIDTH`, 5: address width of the register file under test; N = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width.
- `READ_LAT`, 1: cycles from a read command (CSN_T=0, WEN_T=1) to valid Q_T; legal values 0..3.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `bist_start_i`  in  1  one-cycle request to run the test; sampled only in IDLE or DONE.
- `bist_done_o`  out  1  test finished; held until the next accepted start.
- `bist_fail_o`  out  1  mismatch detected; valid while bist_done_o=1.
- `bist_fail_addr_o`  out  ADDR_WIDTH  address of the first mismatch.
- `bist_fail_elem_o`  out  3  march element index (0..5) of the first mismatch.
- `BIST`  out  1  test-mode enable to the wrapper; high only in RUN.
- `CSN_T`  out  1  active-low chip select.
- `WEN_T`  out  1  active-low write enable.
- `A_T`  out  ADDR_WIDTH  test address.
- `D_T`  out  DATA_WIDTH  test write data.
- `Q_T`  in  DATA_WIDTH  test read data from the wrapper.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on bist_start_i.
  - RUN -> DONE after the last op of M5, or on the first mismatch.
  - DONE -> RUN on bist_start_i.
- Starting a run clears done, fail, fail_addr and fail_elem.
- March elements, using background pattern B0 = all zeros and B1 = all ones:
  - M0 ascending: w0.
  - M1 ascending: r0, w1.
  - M2 ascending: r1, w0.
  - M3 descending: r0, w1.
  - M4 descending: r1, w0.
  - M5 ascending: r0.
- Ascending elements run address 0..N-1; descending elements run N-1..0.
- All ops of an element are applied to one address before the address advances.
- After the last address of an element, the controller moves to the next element's first address with no idle cycle.
- Write op: one cycle with CSN_T=0, WEN_T=0, A_T=addr, D_T=pattern.
- Read op: one issue cycle with CSN_T=0, WEN_T=1, A_T=addr, D_T=0, followed by READ_LAT wait cycles with CSN_T=1, WEN_T=1 and A_T held.
- Comparison: Q_T is compared against the expected pattern (registered at issue) in the last cycle of the read op. With READ_LAT=0, that is the issue cycle itself.
- On a mismatch:
  - set fail, capture addr and element index;
  - go to DONE next cycle with no further accesses.
- All outputs are registered.
- Outside RUN: BIST=0, CSN_T=1, WEN_T=1, A_T=0, D_T=0.
- bist_start_i is ignored while in RUN.

## Timing
- Reset values: BIST=0, CSN_T=1, WEN_T=1, A_T=0, D_T=0, bist_done_o=0, bist_fail_o=0, bist_fail_addr_o=0, bist_fail_elem_o=0; state IDLE.
- A start sampled at edge t gives BIST=1 and the first access (M0 w0 @ addr 0) in cycle t+1.
- Length of a clean run: 5N write cycles + 5N·(1+READ_LAT) read cycles. For N=32 and READ_LAT=1 this is 480 cycles.
- bist_done_o rises in the cycle after the last RUN cycle. BIST falls in that same cycle.
- Fail abort: done=1 and fail=1 in the cycle after the compare cycle that mismatched.
- Reset asserted mid-run immediately forces all outputs to their reset values. No partial result is retained.
- Address counter: wraps modulo N with no overflow flag. The element-end check uses the address value (N-1 when ascending, 0 when descending) combined with the last op of the element.
- N=2 (ADDR_WIDTH=1) must work; descending elements then visit addresses 1, 0.

## Test plan
- Clean model, N=32, READ_LAT=1, pulse start -> BIST high for exactly 480 cycles; first access w @ addr 0, D_T=0; done=1, fail=0 the cycle after.
- Model bit 3 of addr 5 stuck at 1 -> M1 r0 @ addr 5 mismatches; done=1, fail=1, fail_addr=5, fail_elem=1; no access after the compare cycle.
- Coupling fault: writing 1 to addr 9 flips addr 8 to 1 -> fail_elem=3, fail_addr=8 (detected by the descending r0).
- READ_LAT=0 and READ_LAT=3 on a clean model -> run lengths of 320 and 800 cycles for N=32; no false fails.
- rst_n pulsed low at cycle 100 of a run -> outputs return to reset values asynchronously. A later start runs the full 480 cycles and passes.
- Start pulsed during RUN is ignored. Start from DONE after a failed run clears fail and runs again; a clean model then gives done=1, fail=0.
